// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types for the I2C command sequencer.
//   seq_state_e : sequencer FSM encoding (IDLE, ISSUE, WAIT_DONE, RESP)
//   CMD_W       : queued command width, {rw, dev7, inner8, data8}
//   cmd_t       : packed view of one queued command
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } seq_state_e;

  localparam int CMD_W = 24;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] inner;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: DEPTH x W command queue with registered full/empty flags.
//   clk, rst_n      : clock, async active-low reset
//   push_i, wdata_i : write strobe and data (ignored while full)
//   pop_i           : read strobe (ignored while empty)
//   rdata_o         : head entry (valid while !empty_o)
//   full_o, empty_o : registered occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         full_q, full_d, empty_q, empty_d;
  logic         do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host I2C transactions and issues them one at a
// time to the i2cSend engine, returning one response per transaction in order.
//   Host command : cmd_valid/cmd_ready, cmd_rw, cmd_dev_addr, cmd_inner_addr, cmd_wdata
//   To i2cSend   : send_enable, dev_addr, dev_inner_addr, send_data, rw
//   From i2cSend : send_done (level), read_data_in
//   Response     : rsp_valid/rsp_ready, rsp_rw, rsp_data, rsp_err
//   Status       : busy (queue non-empty or FSM not IDLE)
//   clk, rst     : clock, async active-low reset
// Optional build macro I2C_SEQ_TIMEOUT_EN: abort WAIT_DONE after TIMEOUT
// cycles without a send_done rising edge, reporting rsp_err=1. Without it
// WAIT_DONE waits indefinitely and rsp_err is constant 0.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_inner_addr,
  input  logic [7:0] cmd_wdata,
  output logic       send_enable,
  output logic [6:0] dev_addr,
  output logic [7:0] dev_inner_addr,
  output logic [7:0] send_data,
  output logic       rw,
  input  logic       send_done,
  input  logic [7:0] read_data_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_rw,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_bad_param
    $error("i2c_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT in [2,65536]");
  end

  seq_state_e state_q;
  cmd_t       wr_cmd, head;
  logic       fifo_full, fifo_empty, pop;
  logic       send_enable_q, rw_q, rsp_valid_q, rsp_rw_q, rsp_err_q, done_prev_q;
  logic [6:0] dev_addr_q;
  logic [7:0] inner_q, data_q, rsp_data_q;
  logic       done_edge, tmo_hit, next_ok;

  assign wr_cmd = '{rw: cmd_rw, dev: cmd_dev_addr, inner: cmd_inner_addr, data: cmd_wdata};

  i2c_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (cmd_valid),
    .wdata_i (wr_cmd),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next head is taken from IDLE, or directly from RESP on the response
  // handshake so back-to-back transactions do not pass through IDLE.
  assign next_ok   = (state_q == IDLE) || (state_q == RESP && rsp_ready);
  assign pop       = next_ok & ~fifo_empty;
  // A level already high when WAIT_DONE begins is not a completion.
  assign done_edge = send_done & ~done_prev_q;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q;

  // Cleared during ISSUE so it reads 0 on the first WAIT_DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     tmo_cnt_q <= '0;
    else if (state_q == ISSUE)    tmo_cnt_q <= '0;
    else if (state_q == WAIT_DONE) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign tmo_hit = (state_q == WAIT_DONE) && (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      send_enable_q <= 1'b0;
      dev_addr_q    <= '0;
      inner_q       <= '0;
      data_q        <= '0;
      rw_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      done_prev_q   <= 1'b0;
    end else begin
      done_prev_q <= send_done;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            dev_addr_q    <= head.dev;
            inner_q       <= head.inner;
            data_q        <= head.data;
            rw_q          <= head.rw;
            send_enable_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (done_edge) begin
            send_enable_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= rw_q;
            rsp_data_q    <= rw_q ? read_data_in : 8'h00;
            rsp_err_q     <= 1'b0;
            state_q       <= RESP;
          end else if (tmo_hit) begin
            send_enable_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= rw_q;
            rsp_data_q    <= 8'h00;
            rsp_err_q     <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (!fifo_empty) begin
              dev_addr_q    <= head.dev;
              inner_q       <= head.inner;
              data_q        <= head.data;
              rw_q          <= head.rw;
              send_enable_q <= 1'b1;
              state_q       <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = ~fifo_full;
  assign send_enable    = send_enable_q;
  assign dev_addr       = dev_addr_q;
  assign dev_inner_addr = inner_q;
  assign send_data      = data_q;
  assign rw             = rw_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rw         = rsp_rw_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = ~fifo_empty | (state_q != IDLE);

endmodule
